// File: rtl/luma_ds_pkg.sv
// luma_ds_pkg: shared sizes and arithmetic types for the 2x2 luma box downsampler.
package luma_ds_pkg;
   localparam int IN_WIDTH      = 640;
   localparam int IN_HEIGHT     = 360;
   localparam int PIX_WIDTH     = 8;
   localparam int FB_DATA_WIDTH = 16;
   localparam int OUT_WIDTH     = IN_WIDTH / 2;
   localparam int OUT_HEIGHT    = IN_HEIGHT / 2;
   localparam int FB_DEPTH      = OUT_WIDTH * OUT_HEIGHT;
   localparam int ADDR_WIDTH    = $clog2(FB_DEPTH);
   typedef logic [PIX_WIDTH:0]   pair_sum_t;
   typedef logic [PIX_WIDTH+1:0] sum4_t;
endpackage

// File: rtl/luma_line_buffer.sv
// luma_line_buffer: one output row of horizontal pair sums from the even input row;
// one write port and one registered read port so it maps onto block or distributed RAM.
module luma_line_buffer #(
   parameter int DEPTH = 320,
   parameter int WIDTH = 9,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_in,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk_in) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/luma_box_downsampler.sv
// luma_box_downsampler: 2x2 box average of the luma pixel stream into
// quarter-resolution frame-buffer write beats (addr, data, we).
module luma_box_downsampler #(
   parameter int HCOUNT_WIDTH  = 10,
   parameter int VCOUNT_WIDTH  = 9,
   parameter int IN_WIDTH      = luma_ds_pkg::IN_WIDTH,
   parameter int IN_HEIGHT     = luma_ds_pkg::IN_HEIGHT,
   parameter int PIX_WIDTH     = luma_ds_pkg::PIX_WIDTH,
   parameter int FB_DATA_WIDTH = luma_ds_pkg::FB_DATA_WIDTH,
   parameter int ADDR_WIDTH    = $clog2((IN_WIDTH / 2) * (IN_HEIGHT / 2))
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     pixel_valid_in,
   input  logic [HCOUNT_WIDTH-1:0]  pixel_hcount_in,
   input  logic [VCOUNT_WIDTH-1:0]  pixel_vcount_in,
   input  logic [PIX_WIDTH-1:0]     pixel_data_in,
   output logic                     wr_valid_out,
   output logic [ADDR_WIDTH-1:0]    wr_addr_out,
   output logic [FB_DATA_WIDTH-1:0] wr_data_out,
   output logic                     frame_done_out
);
   import luma_ds_pkg::*;
   localparam int OW = IN_WIDTH / 2;
   localparam int CW = $clog2(OW);
   localparam int TW = VCOUNT_WIDTH - 1;
   localparam logic [HCOUNT_WIDTH-1:0] H_LIM = HCOUNT_WIDTH'(IN_WIDTH);
   localparam logic [VCOUNT_WIDTH-1:0] V_LIM = VCOUNT_WIDTH'(IN_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((IN_WIDTH / 2) * (IN_HEIGHT / 2) - 1);

   logic acc, odd_col, odd_row, pair_hit, lb_we, lb_re, odd_hit, pair_ok, s1_valid;
   logic [CW-1:0] col, s1_col;
   logic [TW-1:0] vh, row_tag;
   logic [OW-1:0] col_ok;
   logic [HCOUNT_WIDTH-1:0] pair_h;
   logic [PIX_WIDTH-1:0] pair_lo;
   logic [ADDR_WIDTH-1:0] s1_base, s1_addr;
   pair_sum_t pair_sum, line_rd;
   sum4_t s1_sum, rnd;

   assign acc      = pixel_valid_in && pixel_hcount_in < H_LIM && pixel_vcount_in < V_LIM;
   assign odd_col  = pixel_hcount_in[0];
   assign odd_row  = pixel_vcount_in[0];
   assign col      = CW'(pixel_hcount_in >> 1);
   assign vh       = pixel_vcount_in[VCOUNT_WIDTH-1:1];
   assign pair_hit = acc && odd_col && pair_ok && {pair_h[HCOUNT_WIDTH-1:1], 1'b1} == pixel_hcount_in;
   assign pair_sum = pair_sum_t'(pair_lo) + pair_sum_t'(pixel_data_in);
   assign lb_we    = pair_hit && !odd_row;
   assign lb_re    = acc && !odd_col && odd_row;
   // col_ok keeps a stale entry (dropped even-row pair) from being averaged
   assign odd_hit  = pair_hit && odd_row && row_tag == vh && col_ok[col];
   assign s1_addr  = s1_base + ADDR_WIDTH'(s1_col);
   assign rnd      = s1_sum + sum4_t'(2);

   luma_line_buffer #(.DEPTH(OW), .WIDTH(PIX_WIDTH + 1)) u_line_buffer (
      .clk_in(clk_in),
      .we(lb_we),
      .waddr(col),
      .wdata(pair_sum),
      .re(lb_re),
      .raddr(col),
      .rdata(line_rd)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pair_ok        <= 1'b0;
         pair_h         <= '0;
         pair_lo        <= '0;
         row_tag        <= '1;
         col_ok         <= '0;
         s1_valid       <= 1'b0;
         s1_base        <= '0;
         s1_col         <= '0;
         s1_sum         <= '0;
         wr_valid_out   <= 1'b0;
         wr_addr_out    <= '0;
         wr_data_out    <= '0;
         frame_done_out <= 1'b0;
      end else begin
         if (acc && !odd_col) begin
            pair_ok <= 1'b1;
            pair_h  <= pixel_hcount_in;
            pair_lo <= pixel_data_in;
         end else if (acc) begin
            pair_ok <= 1'b0;
         end
         if (lb_we) begin
            row_tag <= vh;
            col_ok  <= ((row_tag == vh) ? col_ok : '0) | (OW'(1) << col);
         end
         s1_valid <= odd_hit;
         if (odd_hit) begin
            s1_base <= ADDR_WIDTH'(vh) * ADDR_WIDTH'(OW);
            s1_col  <= col;
            s1_sum  <= sum4_t'(line_rd) + sum4_t'(pair_sum);
         end
         wr_valid_out   <= s1_valid;
         frame_done_out <= s1_valid && s1_addr == LAST;
         if (s1_valid) begin
            wr_addr_out <= s1_addr;
            wr_data_out <= FB_DATA_WIDTH'(rnd[PIX_WIDTH+1:2]);
         end
      end
   end
endmodule
